hd_trace_logger: RTL and testbench
==================================

# hd_trace_logger

Leakage-model logger sitting directly downstream of the square-and-multiply exponentiation datapath. It receives one 64-bit intermediate `z` value per exponent round and computes two values per round:
- the Hamming weight (HW) of the value;
- the Hamming distance (HD) from the previous round's value.

It buffers one trace of per-round records and drains them over a ready/valid port. Measured power traces are correlated against this stream in the side-channel experiments.

## Interface
Parameters:
- `WIDTH`, 64: width of the intermediate value.
- `DEPTH`, 8: rounds per trace, equal to the exponent bit count.
- `CW`, 7: width of the HW/HD counts, clog2(WIDTH+1).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a new trace.
- `in_valid` in 1: `in_data` holds the current round's intermediate.
- `in_data` in WIDTH: round intermediate `z`.
- `in_last` in 1: marks the final round of the trace.
- `out_valid` out 1: a record is presented.
- `out_ready` in 1: the consumer accepts the record.
- `out_idx` out 3: round index of the record.
- `out_hw` out CW: HW of that round's value.
- `out_hd` out CW: HD from the previous value.
- `out_last` out 1: final record of the trace.
- `sum_hd` out 10: accumulated HD over the trace.
- `busy` out 1: high in CAPTURE or DRAIN.
- `overflow` out 1: sticky flag, a sample was dropped.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `start` → CAPTURE, with these actions on the same edge: `prev` ← 64'h1 (the exponentiation start value), `wr_ptr` ← 0, `rd_ptr` ← 0, `sum_hd` ← 0, `overflow` ← 0.
  - `in_valid` in IDLE is ignored, with no flag.
- CAPTURE, on each `in_valid`:
  - Write record {idx=`wr_ptr`, hw=popcount(`in_data`), hd=popcount(`in_data` ^ `prev`)} to `buf[wr_ptr]`.
  - Update `prev` ← `in_data`, `sum_hd` += hd, `wr_ptr` += 1.
  - Go to DRAIN when `in_last` is set or `wr_ptr` == DEPTH-1 on that capture.
  - A trace therefore holds 1 to DEPTH records.
- DRAIN:
  - `out_valid` = 1; `out_*` are driven from `buf[rd_ptr]`.
  - `out_last` = (`rd_ptr` == `wr_ptr`-1).
  - On `out_valid & out_ready`: `rd_ptr` += 1. If `out_last` was high, go to IDLE.
  - `in_valid` in DRAIN drops the sample and sets `overflow`.
- `start` in CAPTURE or DRAIN aborts the current trace and restarts with the same actions as from IDLE. The old trace's records are discarded and never presented.
- Width rules:
  - HW and HD are always ≤ 64, so they fit CW=7 bits.
  - `sum_hd` ≤ 8·64 = 512, so it fits 10 bits. No saturation is needed.
- `sum_hd` and `overflow` hold their values in IDLE until the next `start`.

## Timing
- Reset values (async assert):
  - State IDLE.
  - `out_valid`, `out_last`, `busy`, `overflow` = 0.
  - `out_idx`, `out_hw`, `out_hd` = 0.
  - `sum_hd` = 0; `prev` = 64'h1.
- Reset asserted mid-trace clears everything immediately, and no record is presented afterwards.
- Capture latency:
  - The record is written on the edge where `in_valid` is sampled.
  - The popcount is combinational into the buffer register.
- The last capture edge enters DRAIN. `out_valid` is high in the very next cycle, so the first record is available one cycle after the final sample.
- `out_*` are register-sourced: buffer read is a mux over registers, no SRAM.
- Under `out_ready` = 0, `out_*` hold stable.
- One record transfers per cycle under continuous `out_ready`.
- `start` and `in_valid` in the same cycle: `start` wins and the sample is dropped. `overflow` is not set, because `start` clears it.
- `busy` is a registered function of state.

## Structure
- Package `hd_trace_pkg` holds `WIDTH`, `DEPTH`, `CW`, the state enum (IDLE/CAPTURE/DRAIN), and the record struct {idx, hw, hd}.
- Sub-module `popcount64`: combinational 64-bit adder-tree HW. It is instantiated twice: once on `in_data`, once on `in_data ^ prev`.

## Test plan
- Basic trace: `start`, then 64'h0000000000000003, then 64'hFFFFFFFFFFFFFFFF with `in_last`. Expect:
  - records (0, hw 2, hd 1) and (1, hw 64, hd 62);
  - `out_last` on the second record;
  - `sum_hd` = 63, then IDLE.
- Full depth: 8 samples without `in_last`. Expect:
  - auto-DRAIN after the 8th;
  - a 9th `in_valid` during DRAIN sets `overflow` = 1;
  - 8 records with idx 0..7.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DRAIN. Expect `out_valid` = 1 and the record unchanged; then 1 record per cycle once `out_ready` = 1.
- Abort: `start` while record 3 of 8 is presented. Expect:
  - next cycle in CAPTURE, `out_valid` = 0, `sum_hd` = 0;
  - the new trace's idx restarts at 0.
- Reset mid-capture: assert `rst` after 4 samples. Expect all outputs 0 asynchronously; after release, state IDLE and a subsequent trace computes HD from 64'h1.

Source files
------------

// File: rtl/hd_trace_pkg.sv
// Shared constants, FSM states and the per-round record layout for the
// Hamming-distance trace logger.
package hd_trace_pkg;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int CW    = 7;
  localparam int IW    = $clog2(DEPTH);
  localparam int SW    = 10;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [CW-1:0] hw;
    logic [CW-1:0] hd;
  } rec_t;
endpackage

// File: rtl/popcount64.sv
// Combinational 64-bit population count built as a balanced adder tree.
module popcount64
  import hd_trace_pkg::*;
(
  input  logic [63:0]   data,
  output logic [CW-1:0] cnt
);
  logic [1:0] l1 [32];
  logic [2:0] l2 [16];
  logic [3:0] l3 [8];
  logic [4:0] l4 [4];
  logic [5:0] l5 [2];

  // Each level is one bit wider than its children, so no sum can overflow.
  always_comb begin
    for (int i = 0; i < 32; i++) l1[i] = {1'b0, data[2*i]} + {1'b0, data[2*i+1]};
    for (int i = 0; i < 16; i++) l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
    for (int i = 0; i < 8; i++)  l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
    for (int i = 0; i < 4; i++)  l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
    for (int i = 0; i < 2; i++)  l5[i] = {1'b0, l4[2*i]} + {1'b0, l4[2*i+1]};
    cnt = {1'b0, l5[0]} + {1'b0, l5[1]};
  end
endmodule

// File: rtl/hd_trace_logger.sv
// Captures one trace of per-round HW/HD records from the exponentiation
// datapath and drains them over a ready/valid port.
module hd_trace_logger #(
  parameter int WIDTH = hd_trace_pkg::WIDTH,
  parameter int DEPTH = hd_trace_pkg::DEPTH,
  parameter int CW    = hd_trace_pkg::CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_idx,
  output logic [CW-1:0]    out_hw,
  output logic [CW-1:0]    out_hd,
  output logic             out_last,
  output logic [9:0]       sum_hd,
  output logic             busy,
  output logic             overflow
);
  import hd_trace_pkg::*;

  localparam int PW = $clog2(DEPTH) + 1;

  state_t           state;
  rec_t             rec_buf [DEPTH];
  rec_t             rd_rec;
  logic [WIDTH-1:0] prev;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_hw, cnt_hd;
  logic             last_rec;

  popcount64 u_pc_hw (.data(in_data),        .cnt(cnt_hw));
  popcount64 u_pc_hd (.data(in_data ^ prev), .cnt(cnt_hd));

  assign rd_rec   = rec_buf[rd_ptr[IW-1:0]];
  assign last_rec = (rd_ptr == wr_ptr - PW'(1));

  // Outputs are zero outside DRAIN so stale records never leak out.
  assign out_idx  = out_valid ? rd_rec.idx : '0;
  assign out_hw   = out_valid ? rd_rec.hw  : '0;
  assign out_hd   = out_valid ? rd_rec.hd  : '0;
  assign out_last = out_valid & last_rec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      prev      <= WIDTH'(1);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sum_hd    <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rec_buf[i] <= '0;
    end else if (start) begin
      // Start wins over everything, including a coincident sample.
      state     <= CAPTURE;
      busy      <= 1'b1;
      out_valid <= 1'b0;
      prev      <= WIDTH'(1);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sum_hd    <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        CAPTURE: if (in_valid) begin
          rec_buf[wr_ptr[IW-1:0]] <= '{idx: wr_ptr[IW-1:0], hw: cnt_hw, hd: cnt_hd};
          prev   <= in_data;
          sum_hd <= sum_hd + 10'(cnt_hd);
          wr_ptr <= wr_ptr + PW'(1);
          if (in_last || wr_ptr == PW'(DEPTH - 1)) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (in_valid) overflow <= 1'b1;
          if (out_ready) begin
            rd_ptr <= rd_ptr + PW'(1);
            if (last_rec) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hd_trace_logger.sv
// Randomized scoreboard bench for hd_trace_logger: stimulus pushes expected
// records, a negedge monitor pops and compares them on each handshake.
module tb_hd_trace_logger;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic        out_valid, out_last, busy, overflow;
  logic [2:0]  out_idx;
  logic [6:0]  out_hw, out_hd;
  logic [9:0]  sum_hd;

  hd_trace_logger dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_hw(out_hw), .out_hd(out_hd), .out_last(out_last),
    .sum_hd(sum_hd), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int hw; int hd; bit last; } exp_t;
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_cmp = 0, n_err = 0;
  logic [63:0] m_prev;
  int          m_sum, m_cnt;
  bit          m_ovf, m_busy, m_drain;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return '1;
      2: return 64'h1;
      3: return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One cycle of stimulus; the reference model consumes it at issue time.
  task automatic step(input bit s, input bit v, input logic [63:0] d, input bit l, input bit r);
    exp_t e;
    @(posedge clk); #1;
    if (m_drain && exp_q.size() == 0) begin m_busy = 0; m_drain = 0; end
    start = s; in_valid = v; in_data = d; in_last = l; out_ready = r;
    if (s) begin
      exp_q.delete(); m_prev = 64'h1; m_sum = 0; m_cnt = 0; m_ovf = 0;
      m_busy = 1; m_drain = 0;
    end else if (v && m_busy && !m_drain) begin
      e.idx = m_cnt; e.hw = $countones(d); e.hd = $countones(d ^ m_prev);
      e.last = l || (m_cnt == 7);
      exp_q.push_back(e);
      m_sum += e.hd; m_prev = d; m_cnt++;
      if (e.last) m_drain = 1;
    end else if (v && m_drain) begin
      m_ovf = 1;
    end
  endtask

  task automatic drain_and_check(input string nm, input bit rnd_ready);
    int g = 0;
    while (exp_q.size() > 0 && g < 300) begin
      step(0, rnd_ready && $urandom_range(0, 5) == 0, rnd64(), 0,
           rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      g++;
    end
    chk({nm, "_drain_left"}, 64'(exp_q.size()), 0);
    step(0, 1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 1)), 1);
    @(negedge clk);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_sum_hd"}, sum_hd, 64'(m_sum));
    chk({nm, "_overflow"}, overflow, m_ovf);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_last"}, out_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_overflow"}, overflow, 0);
    chk({nm, "_out_idx"}, out_idx, 0);
    chk({nm, "_out_hw"}, out_hw, 0);
    chk({nm, "_out_hd"}, out_hd, 0);
    chk({nm, "_sum_hd"}, sum_hd, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_record: idx %0d hw %0d hd %0d, none expected", out_idx, out_hw, out_hd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rec_idx", out_idx, 64'(mon_e.idx));
        chk("rec_hw", out_hw, 64'(mon_e.hw));
        chk("rec_hd", out_hd, 64'(mon_e.hd));
        chk("rec_last", out_last, mon_e.last);
      end
    end
  end

  initial begin
    m_prev = 64'h1; m_sum = 0; m_cnt = 0; m_ovf = 0; m_busy = 0; m_drain = 0;
    #1 chk_all_zero("reset");
    #20 rst = 0;

    // Basic trace
    step(1, 0, 0, 0, 1);
    step(0, 1, 64'h3, 0, 1);
    step(0, 1, '1, 1, 1);
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("basic_first_latency", out_valid, 1);
    chk("basic_model_sum", 64'(m_sum), 63);
    drain_and_check("basic", 0);

    // Full depth, overflow, backpressure, one record per cycle
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, rnd64(), 0, 0);
    step(0, 1, rnd64(), 0, 0);
    @(negedge clk);
    chk("full_auto_drain", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_idx", out_idx, 64'(exp_q[0].idx));
      chk("bp_hw", out_hw, 64'(exp_q[0].hw));
      chk("bp_hd", out_hd, 64'(exp_q[0].hd));
    end
    chk("full_overflow", overflow, 1);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_rate_busy", busy, 0);
    chk("full_rate_left", 64'(exp_q.size()), 0);
    chk("full_overflow_sticky", overflow, 1);
    chk("full_sum_hd", sum_hd, 64'(m_sum));

    // Abort on record 3, with a coincident sample that must be dropped
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, rnd64(), 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort_presenting", out_idx, 3);
    step(1, 1, rnd64(), 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort_busy", busy, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_sum_hd", sum_hd, 0);
    chk("abort_overflow", overflow, 0);
    step(0, 1, rnd64(), 0, 1);
    step(0, 1, rnd64(), 1, 1);
    drain_and_check("abort", 0);

    // Asynchronous reset mid-capture
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, rnd64() | 64'h2, 0, 0);
    #2 rst = 1;
    #1 chk_all_zero("midrst");
    exp_q.delete(); m_busy = 0; m_drain = 0; m_sum = 0; m_ovf = 0;
    @(negedge clk); rst = 0;
    step(0, 1, rnd64(), 1, 1);
    @(negedge clk);
    chk("midrst_idle_valid", out_valid, 0);
    chk("midrst_idle_busy", busy, 0);
    step(1, 0, 0, 0, 1);
    step(0, 1, 64'h3, 1, 1);
    drain_and_check("postrst", 0);
    chk("postrst_hd_from_one", sum_hd, 1);

    // Randomized traces
    for (int t = 0; t < 25; t++) begin
      int len;
      bit use_last;
      len = $urandom_range(1, 8);
      use_last = (len < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < len; ) begin
        if ($urandom_range(0, 3) == 0) step(0, 0, rnd64(), 0, 1'($urandom_range(0, 1)));
        else begin
          step(0, 1, rnd64(), (k == len - 1) && use_last, 1'($urandom_range(0, 1)));
          k++;
        end
      end
      drain_and_check("rand", 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
